// File: rtl/hart_issue_sched_if.sv
// Hart issue scheduler interface: the hart_state vectors and IF stall coming in,
// the IF-slot selection, the switch hint and the per-hart issue counters going out.
// The master side is the pipeline (hart_state and IF stage); the slave side is the scheduler.
interface hart_issue_sched_if #(
   parameter int HART_NUM = 4,
   parameter int STAT_W   = 16
);
   logic [HART_NUM-1:0]        acti_hstate;
   logic [HART_NUM-1:0]        prim_hstate;
   logic                       if_stall;
   logic [HART_NUM-1:0]        if_hstate;
   logic                       if_valid;
   logic                       hart_switch;
   logic [HART_NUM*STAT_W-1:0] issue_cnt;

   modport master (
      output acti_hstate, prim_hstate, if_stall,
      input  if_hstate, if_valid, hart_switch, issue_cnt
   );

   modport slave (
      input  acti_hstate, prim_hstate, if_stall,
      output if_hstate, if_valid, hart_switch, issue_cnt
   );
endinterface

// File: rtl/hart_issue_sched.sv
// Fetch-slot scheduler for the multi-hart core. The primary hart receives PRIM_WEIGHT
// consecutive IF slots, then one slot goes to the next active non-primary hart in
// round-robin order. All outputs are registered.
// Optional per-hart issue counters are built when HART_SCHED_STAT_EN is defined;
// otherwise issue_cnt is tied to zero.
// The round-robin index arithmetic wraps naturally, so HART_NUM must be a power of two.
module hart_issue_sched #(
   parameter int HART_NUM    = 4,
   parameter int PRIM_WEIGHT = 3,
   parameter int CNT_W       = 4,
   parameter int STAT_W      = 16
) (
   input logic                clk,
   input logic                rst_n,
   hart_issue_sched_if.slave  sched
);

   localparam int IDX_W = $clog2(HART_NUM);
   localparam logic [CNT_W-1:0] LAST_PRIM = CNT_W'(PRIM_WEIGHT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRIM = 2'd1,
      RR   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [HART_NUM-1:0] rr_ptr_q, rr_ptr_d;
   logic [HART_NUM-1:0] hstate_q, hstate_d;
   logic                valid_q, valid_d;
   logic                switch_q, switch_d;

   logic [HART_NUM-1:0] acti;
   logic [HART_NUM-1:0] prim_raw;
   logic [HART_NUM-1:0] prim_sel;
   logic [HART_NUM-1:0] others;
   logic [HART_NUM-1:0] rr_pick;
   logic [IDX_W-1:0]    ptr_idx;
   logic [IDX_W-1:0]    cand_idx;
   logic                prim_found;
   logic                rr_found;
   logic                take_rr;

   assign acti = sched.acti_hstate;

   // Reduce the primary vector to its lowest active bit and derive the non-primary set
   always_comb begin
      prim_raw   = sched.prim_hstate & acti;
      prim_sel   = '0;
      prim_found = 1'b0;
      for (int i = 0; i < HART_NUM; i++) begin
         if (prim_raw[i] && !prim_found) begin
            prim_sel[i] = 1'b1;
            prim_found  = 1'b1;
         end
      end
      others = acti & ~prim_sel;
   end

   // Round-robin pick: first non-primary hart strictly after rr_ptr, falling back to rr_ptr itself
   always_comb begin
      ptr_idx = '0;
      for (int j = 0; j < HART_NUM; j++) begin
         if (rr_ptr_q[j]) ptr_idx = IDX_W'(j);
      end
      rr_pick  = '0;
      rr_found = 1'b0;
      cand_idx = '0;
      for (int k = 1; k <= HART_NUM; k++) begin
         cand_idx = ptr_idx + IDX_W'(k);
         if (others[cand_idx] && !rr_found) begin
            rr_pick[cand_idx] = 1'b1;
            rr_found          = 1'b1;
         end
      end
   end

   // Next-state and next-output logic; a stall freezes everything except the valid drop
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rr_ptr_d = rr_ptr_q;
      hstate_d = hstate_q;
      valid_d  = valid_q;
      switch_d = 1'b0;
      take_rr  = 1'b0;
      if (sched.if_stall) begin
         valid_d = (state_q != IDLE) && ((hstate_q & ~acti) == '0);
      end else if (acti == '0) begin
         state_d  = IDLE;
         hstate_d = '0;
         valid_d  = 1'b0;
         cnt_d    = '0;
      end else begin
         valid_d = 1'b1;
         case (state_q)
            PRIM: begin
               if ((others != '0) && (cnt_q == LAST_PRIM)) begin
                  take_rr = 1'b1;
               end else if (prim_sel != '0) begin
                  hstate_d = prim_sel;
                  cnt_d    = (others == '0) ? '0 : cnt_q + CNT_W'(1);
               end else begin
                  take_rr = 1'b1;
               end
            end
            default: begin
               if (prim_sel != '0) begin
                  state_d  = PRIM;
                  hstate_d = prim_sel;
                  cnt_d    = '0;
               end else begin
                  take_rr = 1'b1;
               end
            end
         endcase
         if (take_rr) begin
            state_d  = RR;
            hstate_d = rr_pick;
            rr_ptr_d = rr_pick;
            cnt_d    = '0;
         end
         switch_d = (hstate_d != '0) && (hstate_d != hstate_q);
      end
   end

   // Scheduler state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rr_ptr_q <= HART_NUM'(1);
         hstate_q <= '0;
         valid_q  <= 1'b0;
         switch_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rr_ptr_q <= rr_ptr_d;
         hstate_q <= hstate_d;
         valid_q  <= valid_d;
         switch_q <= switch_d;
      end
   end

   assign sched.if_hstate   = hstate_q;
   assign sched.if_valid    = valid_q;
   assign sched.hart_switch = switch_q;

`ifdef HART_SCHED_STAT_EN
   logic [HART_NUM*STAT_W-1:0] stat_q;

   // Per-hart slot counters, bumped whenever the incoming selection is a valid slot for that hart
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_q <= '0;
      end else begin
         for (int h = 0; h < HART_NUM; h++) begin
            if (valid_d && hstate_d[h]) begin
               stat_q[h*STAT_W +: STAT_W] <= stat_q[h*STAT_W +: STAT_W] + STAT_W'(1);
            end
         end
      end
   end

   assign sched.issue_cnt = stat_q;
`else
   assign sched.issue_cnt = '0;
`endif

endmodule
